// File: rtl/gtwizard_tx_startup.sv
// TX startup sequencer: waits for QPLL lock after the common reset, walks the GT TX
// reset handshake, and retries (with a saturating count) on lock or reset-done timeouts.
module gtwizard_tx_startup #(
    parameter int STABLE_CLOCK_PERIOD  = 8,
    parameter int QPLL_LOCK_TIMEOUT_NS = 100000,
    parameter int RESETDONE_TIMEOUT_NS = 50000
) (
    input  logic       STABLE_CLOCK,
    input  logic       SOFT_RESET,
    input  logic       COMMON_RESET,
    input  logic       QPLLLOCK,
    input  logic       MMCM_LOCK,
    input  logic       TXRESETDONE,
    output logic       GTTXRESET,
    output logic       TXUSERRDY,
    output logic       QPLL_RESET_REQ,
    output logic       TX_FSM_RESET_DONE,
    output logic [3:0] RETRY_COUNTER
);
    localparam logic [23:0] LOCK_WAIT_MAX = 24'(QPLL_LOCK_TIMEOUT_NS / STABLE_CLOCK_PERIOD);
    localparam logic [23:0] DONE_WAIT_MAX = 24'(RESETDONE_TIMEOUT_NS / STABLE_CLOCK_PERIOD);
    localparam logic [23:0] HOLD_LAST     = 24'd3;

    typedef enum logic [2:0] {
        S_WAIT_COMMON_RESET = 3'd0,
        S_WAIT_QPLL_LOCK    = 3'd1,
        S_HOLD_GTTXRESET    = 3'd2,
        S_WAIT_MMCM_LOCK    = 3'd3,
        S_WAIT_RESET_DONE   = 3'd4,
        S_DONE              = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_lock_sync;
    logic [1:0]  r_mmcm_sync;
    logic [1:0]  r_done_sync;
    logic [23:0] r_timer;
    logic [3:0]  r_retry;
    logic        r_gttxreset;
    logic        r_txuserrdy;
    logic        r_qpll_req;
    logic        r_reset_done;
    logic        w_lock;
    logic        w_mmcm;
    logic        w_done;
    logic        w_enter;
    logic        w_retry;
    logic        w_req;

    always_ff @(posedge STABLE_CLOCK or posedge SOFT_RESET) begin
        if (SOFT_RESET) begin
            r_lock_sync <= 2'b00;
            r_mmcm_sync <= 2'b00;
            r_done_sync <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], QPLLLOCK};
            r_mmcm_sync <= {r_mmcm_sync[0], MMCM_LOCK};
            r_done_sync <= {r_done_sync[0], TXRESETDONE};
        end
    end

    assign w_lock = r_lock_sync[1];
    assign w_mmcm = r_mmcm_sync[1];
    assign w_done = r_done_sync[1];

    // w_enter marks any state entry, including re-entry after a lock timeout, so the timer restarts.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_retry     = 1'b0;
        w_req       = 1'b0;
        if (COMMON_RESET) begin
            w_state_nxt = S_WAIT_QPLL_LOCK;
            w_enter     = 1'b1;
        end else begin
            case (r_state)
                S_WAIT_COMMON_RESET: begin
                end
                S_WAIT_QPLL_LOCK: begin
                    if (w_lock) begin
                        w_state_nxt = S_HOLD_GTTXRESET;
                        w_enter     = 1'b1;
                    end else if (r_timer == LOCK_WAIT_MAX) begin
                        w_enter = 1'b1;
                        w_retry = 1'b1;
                        w_req   = 1'b1;
                    end
                end
                S_HOLD_GTTXRESET: begin
                    if (r_timer == HOLD_LAST) begin
                        w_state_nxt = S_WAIT_MMCM_LOCK;
                        w_enter     = 1'b1;
                    end
                end
                S_WAIT_MMCM_LOCK: begin
                    if (w_mmcm) begin
                        w_state_nxt = S_WAIT_RESET_DONE;
                        w_enter     = 1'b1;
                    end
                end
                S_WAIT_RESET_DONE: begin
                    if (w_done) begin
                        w_state_nxt = S_DONE;
                        w_enter     = 1'b1;
                    end else if (r_timer == DONE_WAIT_MAX) begin
                        w_state_nxt = S_HOLD_GTTXRESET;
                        w_enter     = 1'b1;
                        w_retry     = 1'b1;
                    end
                end
                S_DONE: begin
                    if (!w_lock) begin
                        w_state_nxt = S_WAIT_QPLL_LOCK;
                        w_enter     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_WAIT_COMMON_RESET;
                    w_enter     = 1'b1;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge STABLE_CLOCK or posedge SOFT_RESET) begin
        if (SOFT_RESET) begin
            r_state      <= S_WAIT_COMMON_RESET;
            r_timer      <= 24'd0;
            r_retry      <= 4'd0;
            r_gttxreset  <= 1'b1;
            r_txuserrdy  <= 1'b0;
            r_qpll_req   <= 1'b0;
            r_reset_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_enter ? 24'd0 : r_timer + 24'd1;
            if (w_retry && (r_retry != 4'hF)) begin
                r_retry <= r_retry + 4'd1;
            end
            r_qpll_req   <= w_req;
            r_gttxreset  <= (w_state_nxt == S_WAIT_COMMON_RESET) ||
                            (w_state_nxt == S_WAIT_QPLL_LOCK)    ||
                            (w_state_nxt == S_HOLD_GTTXRESET);
            r_txuserrdy  <= (w_state_nxt == S_WAIT_RESET_DONE) || (w_state_nxt == S_DONE);
            r_reset_done <= (w_state_nxt == S_DONE);
        end
    end

    assign GTTXRESET         = r_gttxreset;
    assign TXUSERRDY         = r_txuserrdy;
    assign QPLL_RESET_REQ    = r_qpll_req;
    assign TX_FSM_RESET_DONE = r_reset_done;
    assign RETRY_COUNTER     = r_retry;
endmodule

// File: doc/gtwizard_tx_startup.md
# gtwizard_tx_startup

TX startup sequencer that sits directly downstream of the QPLL common-reset generator. It consumes the one-cycle COMMON_RESET pulse and then waits for QPLL lock. It sequences GTTXRESET and TXUSERRDY through the GT reset handshake and reports TX_FSM_RESET_DONE to the SATA link layer. Lock and reset-done timeouts re-trigger the QPLL or the GT reset, and each retry is counted.

## Interface
- STABLE_CLOCK_PERIOD, 8, period of STABLE_CLOCK in ns
- QPLL_LOCK_TIMEOUT_NS, 100000, maximum wait for QPLL lock per attempt
- RESETDONE_TIMEOUT_NS, 50000, maximum wait for TXRESETDONE per attempt
- STABLE_CLOCK  in  1  free-running stable clock; all logic is on its rising edge
- SOFT_RESET  in  1  asynchronous, active-high reset of the whole block
- COMMON_RESET  in  1  one-cycle QPLL reset pulse from the upstream common-reset block, synchronous to STABLE_CLOCK
- QPLLLOCK  in  1  QPLL lock, asynchronous
- MMCM_LOCK  in  1  TXUSRCLK MMCM lock, asynchronous
- TXRESETDONE  in  1  GT TX reset done, asynchronous
- GTTXRESET  out  1  GT TX reset
- TXUSERRDY  out  1  user clock ready to the GT
- QPLL_RESET_REQ  out  1  one-cycle QPLL re-reset request; the top level ORs it with COMMON_RESET
- TX_FSM_RESET_DONE  out  1  TX path is up
- RETRY_COUNTER  out  4  number of timeout retries, saturating at 15

## Operation
- QPLLLOCK, MMCM_LOCK and TXRESETDONE each pass through a 2-flop synchronizer (reset to 0). The FSM only uses the synchronized versions.
- Derived cycle counts, integer division:
  - LOCK_WAIT_MAX = QPLL_LOCK_TIMEOUT_NS / STABLE_CLOCK_PERIOD
  - DONE_WAIT_MAX = RESETDONE_TIMEOUT_NS / STABLE_CLOCK_PERIOD
- One 24-bit timer, cleared on every state entry and incremented each cycle otherwise.
- States:
  - WAIT_COMMON_RESET: wait for COMMON_RESET=1, then go to WAIT_QPLL_LOCK.
  - WAIT_QPLL_LOCK:
    - lock=1 → HOLD_GTTXRESET.
    - else timer==LOCK_WAIT_MAX → pulse QPLL_RESET_REQ, RETRY_COUNTER+1, re-enter WAIT_QPLL_LOCK.
  - HOLD_GTTXRESET: stays exactly 4 cycles, then WAIT_MMCM_LOCK.
  - WAIT_MMCM_LOCK: mmcm_lock=1 → WAIT_RESET_DONE. No timeout.
  - WAIT_RESET_DONE:
    - txresetdone=1 → DONE.
    - else timer==DONE_WAIT_MAX → RETRY_COUNTER+1, go to HOLD_GTTXRESET.
  - DONE: lock=0 → WAIT_QPLL_LOCK. Loss of lock does not count as a retry.
- Output values per state (all registered, updated on the same edge as the state):
  - GTTXRESET=1 in WAIT_COMMON_RESET, WAIT_QPLL_LOCK and HOLD_GTTXRESET; 0 otherwise.
  - TXUSERRDY=1 in WAIT_RESET_DONE and DONE.
  - TX_FSM_RESET_DONE=1 only in DONE.
- Priority:
  - COMMON_RESET=1 in any state forces WAIT_QPLL_LOCK with the timer cleared. This overrides lock, timeout and done. RETRY_COUNTER is not changed.
  - In WAIT_QPLL_LOCK and WAIT_RESET_DONE, the success condition wins over a timeout in the same cycle.
- RETRY_COUNTER saturates at 15. Retries continue after saturation. It is cleared only by SOFT_RESET.
- Any undefined state encoding → WAIT_COMMON_RESET.

## Timing
- Reset values (SOFT_RESET high, async assert, sync release):
  - state=WAIT_COMMON_RESET
  - GTTXRESET=1
  - TXUSERRDY=0, QPLL_RESET_REQ=0, TX_FSM_RESET_DONE=0
  - RETRY_COUNTER=0, timer=0, synchronizers=0
- COMMON_RESET sampled high at edge N → state=WAIT_QPLL_LOCK after edge N.
- QPLLLOCK input rise → lock visible 2 edges later → HOLD_GTTXRESET on the next edge → GTTXRESET falls 4 edges after entering HOLD_GTTXRESET.
- Lock timeout: QPLL_RESET_REQ is high for exactly one cycle, beginning at the edge where timer==LOCK_WAIT_MAX is sampled.
- TX_FSM_RESET_DONE and TXUSERRDY fall on the edge after the lock-loss sample; GTTXRESET rises on that same edge.
- A SOFT_RESET assertion mid-sequence drives all outputs to their reset values immediately, with no clock required.

## Test plan
- Use overrides STABLE_CLOCK_PERIOD=10, QPLL_LOCK_TIMEOUT_NS=1000 (100 cycles), RESETDONE_TIMEOUT_NS=500 (50 cycles).
- Nominal bring-up: pulse COMMON_RESET, raise QPLLLOCK 20 cycles later, MMCM_LOCK already 1, raise TXRESETDONE 10 cycles after TXUSERRDY rises → GTTXRESET falls 7 cycles after QPLLLOCK rises (2 sync + 1 + 4 hold); TX_FSM_RESET_DONE=1 3 cycles after TXRESETDONE rises; RETRY_COUNTER=0.
- Lock timeout: COMMON_RESET pulse, QPLLLOCK held 0 → QPLL_RESET_REQ one-cycle pulse every 101 cycles; RETRY_COUNTER 1, 2, 3; GTTXRESET stays 1; then raise QPLLLOCK → normal completion.
- Reset-done timeout: TXRESETDONE held 0 → TXUSERRDY drops and GTTXRESET=1 after 51 cycles in WAIT_RESET_DONE; RETRY_COUNTER increments; 4-cycle hold repeats.
- Lock loss in DONE: drop QPLLLOCK → TX_FSM_RESET_DONE=0, TXUSERRDY=0, GTTXRESET=1 3 cycles later; RETRY_COUNTER unchanged; relock → DONE again.
- Saturation and reset: 20 lock timeouts → RETRY_COUNTER=15 and holds; assert SOFT_RESET asynchronously between clock edges → outputs at reset values before the next edge; COMMON_RESET mid-WAIT_RESET_DONE → WAIT_QPLL_LOCK, GTTXRESET=1.
